// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Register window (offset = address[3:2]):
//   0 TXDATA  write pushes wdata[7:0]; reads 0
//   1 STATUS  {count[12:8], overflow[3], busy[2], empty[1], full[0]}
//   2 CTRL    bit0 enable (R/W); write bit1=1 clears overflow
//   3 reserved
//
// Ports:
//   clk      single clock, rising edge
//   reset    synchronous, active-high
//   address  core bus address
//   wdata    core write data
//   we       core write enable, one write per high cycle
//   sel      combinational window decode
//   rdata    combinational read data, 0 when not selected
//   tx       registered serial output, idle high
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          tx_nxt;
   logic          pop;
   logic          baud_done;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          enable, overflow;

   logic [1:0]    offset;
   logic          push_req, push_acc, ctrl_wr;
   logic          full, empty, busy;

   // Address bits below the word offset and the upper write-data bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{address[1:0], wdata[31:8]};

   // ---------------- decode ----------------
   assign sel      = (address[31:4] == BASE_ADDR[31:4]);
   assign offset   = address[3:2];
   assign push_req = we & sel & (offset == 2'd0);
   assign ctrl_wr  = we & sel & (offset == 2'd2);

   assign full  = (count == DEPTH);
   assign empty = (count == '0);
   assign busy  = (state != S_IDLE);

   // A full FIFO still takes a byte when the head leaves on the same edge.
   assign push_acc = push_req & (~full | pop);

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (offset)
            2'd1:    rdata = {19'd0, 5'(count), 4'd0, overflow, busy, empty, full};
            2'd2:    rdata = {31'd0, enable};
            default: rdata = '0;
         endcase
      end
   end

   // ---------------- FIFO + control registers ----------------
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop)      rd_ptr <= rd_ptr + PW'(1);
         case ({push_acc, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ctrl_wr) enable <= wdata[0];
         // A dropped byte on the same edge as a clear leaves the flag set.
         if (push_req & ~push_acc)    overflow <= 1'b1;
         else if (ctrl_wr & wdata[1]) overflow <= 1'b0;
      end
   end

   // ---------------- serializer FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         tx       <= tx_nxt;
      end
   end

   assign baud_done = (baud_cnt == BAUD_LAST);

   // tx is registered: each branch sets the level the line takes after the edge,
   // so the start bit appears on the same edge the head is popped.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      tx_nxt    = tx;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            baud_nxt = '0;
            tx_nxt   = 1'b1;
            if (enable & ~empty) begin
               state_nxt = S_START;
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_nxt = S_DATA;
               baud_nxt  = '0;
               bit_nxt   = '0;
               tx_nxt    = shreg[0];
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_nxt   = bit_idx + 3'd1;
                  shreg_nxt = {1'b0, shreg[7:1]};
                  tx_nxt    = shreg[1];
               end
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_nxt = '0;
               // Chain straight into the next start bit when more data is waiting.
               if (enable & ~empty) begin
                  state_nxt = S_START;
                  pop       = 1'b1;
                  shreg_nxt = mem[rd_ptr];
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = S_IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt + BW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule
